// File: rtl/mem4x4_ctrl_pkg.sv
// rtl/mem4x4_ctrl_pkg.sv - shared types and default widths for the memory4x4 request controller
// Contents: state_t (controller FSM states), cmd_t (queued command at default widths),
//           DEF_AW / DEF_DW (default address and data widths).
package mem4x4_ctrl_pkg;

    localparam int DEF_AW = 2;
    localparam int DEF_DW = 4;

    // INIT is only reachable when MEM4X4_CTRL_INIT_EN is defined.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RESP  = 3'd3,
        INIT  = 3'd4
    } state_t;

    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem4x4_cmd_fifo.sv
// rtl/mem4x4_cmd_fifo.sv - in-order command FIFO with show-ahead head, full/empty/count
// Ports: clk, rst_n (async active-low); push/push_data in; pop in, pop_data out (head entry);
//        full, empty, count ($clog2(DEPTH)+1 bits) out.
module mem4x4_cmd_fifo
    import mem4x4_ctrl_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = cmd_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          slot_q [DEPTH];
    entry_t          slot_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_en;
    logic            pop_en;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = slot_q[rd_ptr_q];

    // Guard against misuse: a push into a full FIFO or a pop from an empty one is dropped.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
        if (push_en) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem4x4_ctrl.sv
// rtl/mem4x4_ctrl.sv - request-side controller driving memory4x4 addr/din/WE from a queued command stream
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata command channel;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_addr read response channel; mem_addr/mem_din/mem_we to memory,
//        mem_dout from memory; busy (FIFO non-empty or FSM not IDLE).
// Option: MEM4X4_CTRL_INIT_EN - zero-fill every memory address after reset before accepting commands.
module mem4x4_ctrl
    import mem4x4_ctrl_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = 2,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] rsp_addr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(RD_LAT + 1);

`ifdef MEM4X4_CTRL_INIT_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    // Same layout as cmd_t but following this instance's AW/DW.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_cmd_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_din_q, mem_din_d;
    logic            mem_we_q, mem_we_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    // Holds req_ready low through reset and releases it on the first edge afterwards.
    logic            started_q;
`ifdef MEM4X4_CTRL_INIT_EN
    // MSB set means every address has been written.
    logic [AW:0]     init_cnt_q, init_cnt_d;
`endif

    req_cmd_t        req_cmd;
    req_cmd_t        fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign req_cmd = '{we: req_we, addr: req_addr, wdata: req_wdata};

    // Ready depends only on registered state, so a pop in the same cycle never frees a full FIFO.
`ifdef MEM4X4_CTRL_INIT_EN
    assign req_ready = started_q && !fifo_full && (state_q != INIT);
`else
    assign req_ready = started_q && !fifo_full;
`endif
    assign fifo_push = req_valid && req_ready;
    assign busy      = (fifo_count != '0) || (state_q != IDLE);

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_addr  = rsp_addr_q;

    mem4x4_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (req_cmd_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (req_cmd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
        lat_cnt_d   = lat_cnt_q;
        fifo_pop    = 1'b0;
`ifdef MEM4X4_CTRL_INIT_EN
        init_cnt_d  = init_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    mem_addr_d = fifo_head.addr;
                    mem_din_d  = fifo_head.wdata;
                    if (fifo_head.we) begin
                        mem_we_d = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        lat_cnt_d = LW'(RD_LAT);
                        state_d   = READ;
                    end
                end
            end
            // mem_we was high for this one cycle; the memory commits at the edge leaving it.
            WRITE: begin
                state_d = IDLE;
            end
            // Counter value 1 means this edge is the one at which mem_dout becomes valid.
            READ: begin
                if (lat_cnt_q == LW'(1)) begin
                    lat_cnt_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_dout;
                    rsp_addr_d  = mem_addr_q;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`ifdef MEM4X4_CTRL_INIT_EN
            INIT: begin
                if (!init_cnt_q[AW]) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = init_cnt_q[AW-1:0];
                    mem_din_d  = '0;
                    init_cnt_d = init_cnt_q + (AW+1)'(1);
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            lat_cnt_q   <= '0;
            started_q   <= 1'b0;
`ifdef MEM4X4_CTRL_INIT_EN
            init_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            lat_cnt_q   <= lat_cnt_d;
            started_q   <= 1'b1;
`ifdef MEM4X4_CTRL_INIT_EN
            init_cnt_q  <= init_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem4x4_ctrl.sv
// tb/tb_mem4x4_ctrl.sv - self-checking bench for mem4x4_ctrl with a memory4x4 model and in-order reference
module tb_mem4x4_ctrl;

    localparam int AW         = 2;
    localparam int DW         = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int RD_LAT     = 1;
    localparam int NW         = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          busy;

    mem4x4_ctrl #(
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // memory4x4 stand-in: write at the edge while WE is high, data visible one cycle after addr.
    logic          mem_load = 1'b0;
    logic [DW-1:0] pat     [NW];
    logic [DW-1:0] mem_arr [NW];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < NW; i++) mem_arr[i] <= pat[i];
        end else if (mem_we) begin
            mem_arr[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = mem_arr[mem_addr];

    // Reference: each accepted command takes effect in order, so a read returns
    // the value left by all earlier accepted writes. Writes not yet seen on the
    // memory pins keep the overwritten value so a reset can undo them.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] old;
    } wr_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } rd_t;

    wr_t           exp_wr[$];
    rd_t           exp_rd[$];
    logic [DW-1:0] ref_mem [NW];
    int            total = 0;
    int            bad   = 0;
    bit            rand_bp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        wr_t w;
        rd_t r;
        if (!rst_n) begin
            while (exp_wr.size() > 0) begin
                w = exp_wr.pop_back();
                ref_mem[w.a] = w.old;
            end
            exp_rd.delete();
        end
        if (mem_load) begin
            for (int i = 0; i < NW; i++) ref_mem[i] = pat[i];
        end
        if (!rst_n) begin
`ifdef MEM4X4_CTRL_INIT_EN
            for (int i = 0; i < NW; i++) begin
                exp_wr.push_back('{a: AW'(i), d: '0, old: ref_mem[i]});
                ref_mem[i] = '0;
            end
`endif
            return;
        end
        if (mem_we) begin
            chk("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", mem_addr, w.a);
                chk("wr_data", mem_din, w.d);
            end
        end
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                r = exp_rd.pop_front();
                chk("rsp_addr", rsp_addr, r.a);
                chk("rsp_data", rsp_rdata, r.d);
            end
        end
        if (req_valid && req_ready) begin
            if (req_we) begin
                exp_wr.push_back('{a: req_addr, d: req_wdata, old: ref_mem[req_addr]});
                ref_mem[req_addr] = req_wdata;
            end else begin
                exp_rd.push_back('{a: req_addr, d: ref_mem[req_addr]});
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the model samples on the falling edge.
    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (rand_bp) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = req_ready;
            step();
        end
        req_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_left", exp_wr.size() + exp_rd.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] held;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NW; i++) pat[i] = DW'($urandom);
        #2 rst_n = 1'b0;
        #1;

        // Reset values
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
`ifndef MEM4X4_CTRL_INIT_EN
        chk("rst_busy", busy, 0);
`endif
        mem_load = 1'b1;
        step();
        mem_load = 1'b0;
        step();
        rst_n = 1'b1;
        chk("ready_at_release", req_ready, 0);
        step();
`ifdef MEM4X4_CTRL_INIT_EN
        n = 0;
        while (!req_ready && n < 20) begin
            chk("init_ready_low", req_ready, 0);
            chk("init_busy", busy, 1);
            step();
            n++;
        end
        chk("init_done", req_ready, 1);
        chk("init_writes_left", exp_wr.size(), 0);
`else
        chk("ready_after_rst", req_ready, 1);
        chk("busy_after_rst", busy, 0);
`endif

        // Single write: WE for exactly one cycle, one cycle after acceptance
        send(1'b1, 2'd2, 4'b1011);
        chk("wr_we_lat0", mem_we, 0);
        step();
        chk("wr_we", mem_we, 1);
        chk("wr_addr_pin", mem_addr, 2);
        chk("wr_din_pin", mem_din, 4'b1011);
        chk("wr_no_rsp", rsp_valid, 0);
        step();
        chk("wr_we_drop", mem_we, 0);
        chk("wr_busy_done", busy, 0);

        // Isolated read: response after edge k+1+RD_LAT
        send(1'b0, 2'd2, 4'h0);
        chk("rd_lat0", rsp_valid, 0);
        step();
        chk("rd_lat1", rsp_valid, 0);
        step();
        chk("rd_lat2", rsp_valid, 1);
        chk("rd_addr_pin", rsp_addr, 2);
        chk("rd_data_pin", rsp_rdata, 4'b1011);
        step();
        chk("rd_consumed", rsp_valid, 0);

        // Write then read of the same address back to back
        send(1'b1, 2'd0, 4'b0111);
        send(1'b0, 2'd0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("b2b_latency", n, 3);
        chk("b2b_data", rsp_rdata, 4'b0111);
        chk("b2b_addr", rsp_addr, 0);
        step();

        // Backpressure: first response held, FIFO fills, then full-on-pop push refused
        rsp_ready = 1'b0;
        send(1'b0, 2'd1, 4'h0);
        send(1'b0, 2'd2, 4'h0);
        send(1'b0, 2'd3, 4'h0);
        held = ref_mem[1];
        chk("bp_full", req_ready, 0);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_addr", rsp_addr, 1);
        chk("bp_data", rsp_rdata, held);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_addr", rsp_addr, 1);
            chk("bp_hold_data", rsp_rdata, held);
            chk("bp_hold_full", req_ready, 0);
            chk("bp_hold_busy", busy, 1);
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 2'd0;
        rsp_ready = 1'b1;
        chk("full_before_hs", req_ready, 0);
        step();
        chk("full_pop_cycle", req_ready, 0);
        chk("bp_released", rsp_valid, 0);
        step();
        chk("ready_after_pop", req_ready, 1);
        step();
        req_valid = 1'b0;
        drain();

        // Reset in the middle of a read with a write to addr 3 queued behind it
        send(1'b0, 2'd1, 4'h0);
        send(1'b1, 2'd3, ref_mem[3] ^ 4'hF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_ready", req_ready, 0);
`ifndef MEM4X4_CTRL_INIT_EN
        chk("mid_rst_busy", busy, 0);
`endif
        step();
        step();
        rst_n = 1'b1;
`ifndef MEM4X4_CTRL_INIT_EN
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_busy", busy, 0);
        end
`endif
        drain();
        chk("no_write_addr3", mem_arr[3], ref_mem[3]);
        send(1'b0, 2'd3, 4'h0);
        send(1'b0, 2'd1, 4'h0);
        drain();

        // Random traffic with random response backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) step();
            send(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end
        drain();
        rand_bp   = 1'b0;
        rsp_ready = 1'b1;
        drain();
        for (int i = 0; i < NW; i++) chk("final_mem", mem_arr[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
